// File: rtl/sub86_boot_loader_if.sv
// Purpose : byte-stream input and IRAM-write / core-control outputs of the sub86 boot loader.
// Latency : pure signal bundle, no logic.
// Backpr. : RX_VALID/RX_READY handshake; a byte moves when both are high at a rising CLK.
// Signals : RX_DATA/RX_VALID/RX_READY  - incoming byte stream
//           IRAM_A/IRAM_D/IRAM_WEN     - instruction RAM write port (WEN active low)
//           CORE_RSTN/DONE/ERR         - core reset and load status
interface sub86_boot_loader_if #(
  parameter int ADDR_W = 16
) ();
  logic [7:0]        RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic [ADDR_W-1:0] IRAM_A;
  logic [15:0]       IRAM_D;
  logic              IRAM_WEN;
  logic              CORE_RSTN;
  logic              DONE;
  logic              ERR;

  // The loader side.
  modport master (
    input  RX_DATA, RX_VALID,
    output RX_READY, IRAM_A, IRAM_D, IRAM_WEN, CORE_RSTN, DONE, ERR
  );

  // The byte source / RAM / core side.
  modport slave (
    output RX_DATA, RX_VALID,
    input  RX_READY, IRAM_A, IRAM_D, IRAM_WEN, CORE_RSTN, DONE, ERR
  );
endinterface

// File: rtl/sub86_boot_loader.sv
// Purpose : loads a framed program image (0xA5, LEN_LO, LEN_HI, 2*N payload bytes, CHK) into
//           instruction RAM as 16-bit words and releases the core once the checksum is good.
// Latency : all outputs registered; the IRAM write of a word and the core release appear the
//           cycle after the completing byte is accepted.
// Backpr. : RX_READY is high in every state except RUN; one byte per cycle with no stalls.
// Ports   : CLK, RSTN (synchronous, active low); bus = sub86_boot_loader_if.master carrying
//           RX_DATA/RX_VALID/RX_READY, IRAM_A/IRAM_D/IRAM_WEN, CORE_RSTN/DONE/ERR.
// Option  : define SUB86_BOOT_RELOAD_EN to accept a new 0xA5 sync in RUN and reload the image.
module sub86_boot_loader #(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 32768
) (
  input  logic                CLK,
  input  logic                RSTN,
  sub86_boot_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_HI, S_LO, S_CHK, S_RUN, S_ERR
  } state_t;

  localparam logic [7:0]  SYNC  = 8'hA5;
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

`ifdef SUB86_BOOT_RELOAD_EN
  localparam bit RELOAD_EN = 1'b1;
`else
  localparam bit RELOAD_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       k_q, k_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        hi_q, hi_d;
  logic              rx_ready_q, rx_ready_d;
  logic [ADDR_W-1:0] iram_a_q, iram_a_d;
  logic [15:0]       iram_d_q, iram_d_d;
  logic              iram_wen_q, iram_wen_d;
  logic              core_rstn_q, core_rstn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              acc;
  logic [7:0]        rx_byte;
  logic [16:0]       n_new;    // one extra bit so N > MAX_WORDS is a plain compare
  logic [7:0]        sum_new;

  assign acc     = bus.RX_VALID & rx_ready_q;
  assign rx_byte = bus.RX_DATA;
  assign n_new   = {1'b0, rx_byte, len_lo_q};
  assign sum_new = sum_q + rx_byte;

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    n_d         = n_q;
    k_d         = k_q;
    sum_d       = sum_q;
    hi_d        = hi_q;
    iram_a_d    = iram_a_q;   // address/data hold their last value outside the write cycle
    iram_d_d    = iram_d_q;
    iram_wen_d  = 1'b1;
    core_rstn_d = core_rstn_q;
    done_d      = done_q;
    err_d       = err_q;

    if (acc) begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte == SYNC) state_d = S_LEN0;
        end
        S_LEN0: begin
          len_lo_d = rx_byte;
          state_d  = S_LEN1;
        end
        S_LEN1: begin
          n_d   = n_new[15:0];
          k_d   = '0;
          sum_d = '0;           // cleared also for N == 0 so CHK alone must be 0x00
          if (n_new > MAX_N) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_new == '0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_HI;
          end
        end
        S_HI: begin
          hi_d    = rx_byte;
          sum_d   = sum_new;
          state_d = S_LO;
        end
        S_LO: begin
          sum_d      = sum_new;
          iram_wen_d = 1'b0;
          iram_a_d   = {k_q[ADDR_W-2:0], 1'b0};
          iram_d_d   = {hi_q, rx_byte};
          k_d        = k_q + 16'd1;
          state_d    = (k_q + 16'd1 == n_q) ? S_CHK : S_HI;
        end
        S_CHK: begin
          if (sum_new == 8'h00) begin
            state_d     = S_RUN;
            core_rstn_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_RUN: begin
          // Only reachable with the reload option; otherwise RX_READY is low here.
          if (RELOAD_EN && rx_byte == SYNC) begin
            state_d     = S_LEN0;
            core_rstn_d = 1'b0;
            done_d      = 1'b0;
          end
        end
        S_ERR: begin
          if (rx_byte == SYNC) begin
            state_d = S_LEN0;
            err_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Registered ready follows the state being entered.
    rx_ready_d = (state_d != S_RUN) || RELOAD_EN;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      n_q         <= '0;
      k_q         <= '0;
      sum_q       <= '0;
      hi_q        <= '0;
      rx_ready_q  <= 1'b0;
      iram_a_q    <= '0;
      iram_d_q    <= '0;
      iram_wen_q  <= 1'b1;
      core_rstn_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      n_q         <= n_d;
      k_q         <= k_d;
      sum_q       <= sum_d;
      hi_q        <= hi_d;
      rx_ready_q  <= rx_ready_d;
      iram_a_q    <= iram_a_d;
      iram_d_q    <= iram_d_d;
      iram_wen_q  <= iram_wen_d;
      core_rstn_q <= core_rstn_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.RX_READY  = rx_ready_q;
  assign bus.IRAM_A    = iram_a_q;
  assign bus.IRAM_D    = iram_d_q;
  assign bus.IRAM_WEN  = iram_wen_q;
  assign bus.CORE_RSTN = core_rstn_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule
